nes_oam_dma_engine: RTL and testbench
=====================================

// Module: nes_oam_dma_engine
// PURPOSE
//  Parametrised sprite/OAM DMA engine on the CPU clock, between CPU address/data bus and hardware decoder.
//  CPU write to PAGE_REG starts a block copy: XFER_LEN bytes from {page,8'h00} up to DEST_ADDR, read/write pairs.
//  Stalls the CPU (RDY low) for the whole transfer; otherwise passes CPU bus straight through.
//  Successor of fixed 256-byte OAM DMA: configurable length, register/destination addresses, optional parity alignment.
// PARAMETERS
//  XFER_LEN       256      bytes per transfer, 1..256
//  PAGE_REG_ADDR  16'h4014 CPU write address that triggers DMA (data = source page)
//  DEST_ADDR      16'h2004 destination address driven on every write cycle (OAMDATA)
// PORTS
//  clk          in   1   CPU clock; all state on rising edge
//  rst_n        in   1   asynchronous active-low reset
//  cpu_addr_i   in   16  CPU address bus
//  cpu_data_i   in   8   CPU write data
//  cpu_rw_i     in   1   CPU direction, 1=read 0=write
//  bus_data_i   in   8   read data returned from memory
//  bus_addr_o   out  16  address to decoder (CPU or DMA)
//  bus_rw_o     out  1   direction to decoder, 1=read
//  bus_data_o   out  8   write data to decoder (CPU or DMA)
//  cpu_stall_o  out  1   1 = hold CPU (drive RDY = ~cpu_stall_o)
//  busy_o       out  1   1 while state != IDLE
//  done_o       out  1   one-cycle pulse after final write
// BEHAVIOUR
//  Reset: state=IDLE, page=0, idx=0, latch=0, parity=0; cpu_stall_o=0, busy_o=0, done_o=0.
//   Bus outputs pass through.
//  parity flop toggles every clk from reset (CPU get/put cycle tracking).
//  IDLE: bus_addr_o=cpu_addr_i, bus_rw_o=cpu_rw_i, bus_data_o=cpu_data_i (combinational).
//   cpu_addr_i==PAGE_REG_ADDR && cpu_rw_i==0 -> latch page=cpu_data_i, idx=0, go HALT.
//  HALT (1 cycle): cpu_stall_o=1; bus outputs = CPU passthrough so triggering write completes.
//   -> ALIGN if NES_DMA_ALIGN_EN and parity==1, else READ.
//  ALIGN (1 cycle): stall; bus_addr_o=DEST_ADDR, bus_rw_o=1 (dummy read, data discarded) -> READ.
//  READ: stall; bus_addr_o={page,idx}, bus_rw_o=1; latch<=bus_data_i at cycle end -> WRITE.
//  WRITE: stall; bus_addr_o=DEST_ADDR, bus_rw_o=0, bus_data_o=latch; idx++.
//   idx==XFER_LEN-1 -> DONE, else READ.
//  DONE (1 cycle): done_o=1, cpu_stall_o=0, bus passthrough -> IDLE.
//  cpu_stall_o=1 in HALT/ALIGN/READ/WRITE only; busy_o=1 in every state except IDLE.
//  Latency: stall = 1 + 2*XFER_LEN cycles (+1 with ALIGN); default 513/514.
//  idx is 8 bits; source address never crosses page (XFER_LEN<=256); no wrap into next page.
//  PAGE_REG writes while busy_o=1 are ignored (no restart, page unchanged).
//  Read from PAGE_REG_ADDR never triggers.
//  Reset asserted mid-transfer: immediate return to IDLE; stall drops asynchronously; no done_o.
//  XFER_LEN==1: HALT, READ, WRITE, DONE.
// CONFIGURATION
//  NES_DMA_ALIGN_EN defined: ALIGN state active per parity rule above (hardware-accurate 513/514).
//  Not defined: ALIGN state and its logic absent; parity flop may be removed; always 1+2*XFER_LEN.
// TESTING
//  Write 8'h02 to 16'h4014, XFER_LEN=256, no ALIGN -> 256 read/write pairs.
//   Reads 16'h0200..16'h02FF, writes to 16'h2004 with matching data; stall exactly 513 cycles; one done_o.
//  NES_DMA_ALIGN_EN, trigger on parity=1 -> 514 stall cycles, dummy read first.
//   Same trigger on parity=0 -> 513.
//  XFER_LEN=4, page 8'h07, memory 07:00..03 = A1,B2,C3,D4 -> 2004 writes A1,B2,C3,D4; stall 9 cycles.
//  Second 4014 write (data 8'h05) issued mid-transfer -> ignored; source stays page 02; single done_o.
//  rst_n low at byte 100 -> stall and busy drop same cycle; next trigger restarts from idx 0.
//  CPU read of 16'h4014 and write to 16'h4015 -> no stall, bus passthrough unchanged.

Source files
------------

// File: rtl/nes_oam_dma_engine.sv
// nes_oam_dma_engine
// Sprite/OAM block-copy engine that sits between the CPU bus and the address
// decoder. A CPU write to PAGE_REG_ADDR latches a source page and starts
// XFER_LEN read/write pairs: {page,idx} is read, then the byte is written to
// DEST_ADDR. The CPU is held off (cpu_stall_o) for the whole copy. In every
// other state the CPU bus passes straight through to the decoder.
//
// Optional build macro: NES_DMA_ALIGN_EN
//   defined   - a get/put parity flop toggles every clock; when the copy starts
//               on an odd cycle, one dummy read of DEST_ADDR is inserted first.
//   undefined - no ALIGN state and no parity flop; stall is always 1+2*XFER_LEN.

module nes_oam_dma_engine #(
  parameter int unsigned XFER_LEN      = 256,
  parameter logic [15:0] PAGE_REG_ADDR = 16'h4014,
  parameter logic [15:0] DEST_ADDR     = 16'h2004
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cpu_addr_i,
  input  logic [7:0]  cpu_data_i,
  input  logic        cpu_rw_i,
  input  logic [7:0]  bus_data_i,
  output logic [15:0] bus_addr_o,
  output logic        bus_rw_o,
  output logic [7:0]  bus_data_o,
  output logic        cpu_stall_o,
  output logic        busy_o,
  output logic        done_o
);

`ifdef NES_DMA_ALIGN_EN
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_ALIGN = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_e;
`endif

  // Index of the last byte; idx is 8 bits so a 256-byte copy ends at 8'hFF
  // and never carries into the next page.
  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 32'd1);

  state_e      state_q, state_d;
  logic [7:0]  page_q,  page_d;
  logic [7:0]  idx_q,   idx_d;
  logic [7:0]  latch_q, latch_d;
  logic        trigger_s;

  // Only a CPU write to the page register starts a copy; reads never do.
  assign trigger_s = (cpu_addr_i == PAGE_REG_ADDR) && (cpu_rw_i == 1'b0);

`ifdef NES_DMA_ALIGN_EN
  logic parity_q;

  // Free-running get/put cycle tracker, starts at 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= ~parity_q;
    end
  end
`endif

  // State, page, index and data latch registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      page_q  <= 8'h00;
      idx_q   <= 8'h00;
      latch_q <= 8'h00;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      idx_q   <= idx_d;
      latch_q <= latch_d;
    end
  end

  // Next-state logic and bus steering; default is CPU passthrough.
  always_comb begin
    state_d     = state_q;
    page_d      = page_q;
    idx_d       = idx_q;
    latch_d     = latch_q;
    bus_addr_o  = cpu_addr_i;
    bus_rw_o    = cpu_rw_i;
    bus_data_o  = cpu_data_i;
    cpu_stall_o = 1'b0;
    busy_o      = 1'b1;
    done_o      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy_o = 1'b0;
        if (trigger_s) begin
          page_d  = cpu_data_i;
          idx_d   = 8'h00;
          state_d = ST_HALT;
        end else begin
          state_d = ST_IDLE;
        end
      end

      // Bus stays with the CPU so the triggering write can finish.
      ST_HALT: begin
        cpu_stall_o = 1'b1;
`ifdef NES_DMA_ALIGN_EN
        if (parity_q) begin
          state_d = ST_ALIGN;
        end else begin
          state_d = ST_READ;
        end
`else
        state_d = ST_READ;
`endif
      end

`ifdef NES_DMA_ALIGN_EN
      // Dummy read to land the first real read on a get cycle.
      ST_ALIGN: begin
        cpu_stall_o = 1'b1;
        bus_addr_o  = DEST_ADDR;
        bus_rw_o    = 1'b1;
        state_d     = ST_READ;
      end
`endif

      ST_READ: begin
        cpu_stall_o = 1'b1;
        bus_addr_o  = {page_q, idx_q};
        bus_rw_o    = 1'b1;
        latch_d     = bus_data_i;
        state_d     = ST_WRITE;
      end

      ST_WRITE: begin
        cpu_stall_o = 1'b1;
        bus_addr_o  = DEST_ADDR;
        bus_rw_o    = 1'b0;
        bus_data_o  = latch_q;
        idx_d       = idx_q + 8'd1;
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_READ;
        end
      end

      // CPU is released here; done pulses for exactly this cycle.
      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_nes_oam_dma_engine.sv
// Directed bench for nes_oam_dma_engine: a 256-byte instance (a_*) and a
// 4-byte instance (b_*) on a shared clock and reset. Outputs are sampled on
// the falling edge; inputs change 1ns after the rising edge.

module tb_nes_oam_dma_engine;

`ifdef NES_DMA_ALIGN_EN
  localparam bit ALIGN_ON = 1'b1;
`else
  localparam bit ALIGN_ON = 1'b0;
`endif

  logic clk;
  logic rst_n;

  logic [15:0] a_cpu_addr, a_bus_addr;
  logic [7:0]  a_cpu_data, a_bus_din, a_bus_data;
  logic        a_cpu_rw, a_bus_rw, a_stall, a_busy, a_done;

  logic [15:0] b_cpu_addr, b_bus_addr;
  logic [7:0]  b_cpu_data, b_bus_din, b_bus_data;
  logic        b_cpu_rw, b_bus_rw, b_stall, b_busy, b_done;

  int n_tests = 0;
  int n_fail  = 0;
  logic tb_par;

  // Memory image for the 256-byte instance: every byte differs within a page.
  function automatic logic [7:0] mem_a(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Memory image for the 4-byte instance: 07:00..03 = A1,B2,C3,D4.
  function automatic logic [7:0] mem_b(input logic [15:0] a);
    case (a)
      16'h0700: return 8'hA1;
      16'h0701: return 8'hB2;
      16'h0702: return 8'hC3;
      16'h0703: return 8'hD4;
      default:  return 8'h00;
    endcase
  endfunction

  assign a_bus_din = mem_a(a_bus_addr);
  assign b_bus_din = mem_b(b_bus_addr);

  nes_oam_dma_engine u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .cpu_addr_i(a_cpu_addr), .cpu_data_i(a_cpu_data), .cpu_rw_i(a_cpu_rw),
    .bus_data_i(a_bus_din),
    .bus_addr_o(a_bus_addr), .bus_rw_o(a_bus_rw), .bus_data_o(a_bus_data),
    .cpu_stall_o(a_stall), .busy_o(a_busy), .done_o(a_done)
  );

  nes_oam_dma_engine #(.XFER_LEN(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .cpu_addr_i(b_cpu_addr), .cpu_data_i(b_cpu_data), .cpu_rw_i(b_cpu_rw),
    .bus_data_i(b_bus_din),
    .bus_addr_o(b_bus_addr), .bus_rw_o(b_bus_rw), .bus_data_o(b_bus_data),
    .cpu_stall_o(b_stall), .busy_o(b_busy), .done_o(b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference get/put parity: 0 out of reset, flips every clock.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_par <= 1'b0;
    else        tb_par <= ~tb_par;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic a_idle();
    a_cpu_addr = 16'h8000; a_cpu_rw = 1'b1; a_cpu_data = 8'h00;
  endtask

  // Trigger a copy on instance a and check every stalled cycle against the
  // expected bus sequence. mid: inject a second page write (data 05) during
  // the copy. rst_mid: pull reset while byte 100 is being read.
  task automatic run_a(input logic [7:0] page, input bit mid, input bit rst_mid);
    int  n, off, k, done_cnt, stall_cnt;
    bit  al, fin, was_reset;
    a_cpu_addr = 16'h4014; a_cpu_rw = 1'b0; a_cpu_data = page;
    @(negedge clk);
    check_eq("trig_passthru_addr", 32'(a_bus_addr), 32'h4014);
    check_eq("trig_no_stall", 32'(a_stall), 32'd0);
    next_cycle();
    a_idle();
    n = 0; al = 1'b0; fin = 1'b0; was_reset = 1'b0; done_cnt = 0; stall_cnt = 0;
    while (!fin && n < 600) begin
      @(negedge clk);
      if (a_done) done_cnt++;
      if (a_stall) begin
        if (n == 0) begin
          al = ALIGN_ON && tb_par;
          check_eq("halt_passthru_addr", 32'(a_bus_addr), 32'h8000);
          check_eq("halt_busy", 32'(a_busy), 32'd1);
        end else if (al && n == 1) begin
          check_eq("align_addr", 32'(a_bus_addr), 32'h2004);
          check_eq("align_rw", 32'(a_bus_rw), 32'd1);
        end else begin
          off = n - 1 - int'(al);
          k   = off / 2;
          if (off % 2 == 0) begin
            check_eq("read_addr", 32'(a_bus_addr), 32'({page, k[7:0]}));
            check_eq("read_rw", 32'(a_bus_rw), 32'd1);
          end else begin
            check_eq("write_addr", 32'(a_bus_addr), 32'h2004);
            check_eq("write_rw", 32'(a_bus_rw), 32'd0);
            check_eq("write_data", 32'(a_bus_data), 32'(mem_a({page, k[7:0]})));
          end
          if (rst_mid && off == 200) begin
            rst_n = 1'b0;
            #1;
            check_eq("rst_stall_drop", 32'(a_stall), 32'd0);
            check_eq("rst_busy_drop", 32'(a_busy), 32'd0);
            check_eq("rst_no_done", 32'(a_done), 32'd0);
            was_reset = 1'b1;
            fin = 1'b1;
          end
        end
        stall_cnt++;
        n++;
      end else begin
        check_eq("done_pulse", 32'(a_done), 32'd1);
        check_eq("done_busy", 32'(a_busy), 32'd1);
        fin = 1'b1;
      end
      next_cycle();
      if (mid && n == 10) begin
        a_cpu_addr = 16'h4014; a_cpu_rw = 1'b0; a_cpu_data = 8'h05;
      end else begin
        a_idle();
      end
    end
    if (!fin) check_eq("timeout_a", 32'd1, 32'd0);
    if (was_reset) begin
      @(negedge clk);
      rst_n = 1'b1;
      next_cycle();
    end else begin
      check_eq("stall_len", 32'(stall_cnt), 32'(513 + int'(al)));
      @(negedge clk);
      if (a_done) done_cnt++;
      check_eq("done_count", 32'(done_cnt), 32'd1);
      check_eq("idle_busy", 32'(a_busy), 32'd0);
      next_cycle();
    end
  endtask

  // Four-byte copy from page 07 on instance b.
  task automatic run_b();
    logic [7:0] exp_w [4];
    int  w, stall_cnt, n;
    bit  al, fin;
    exp_w[0] = 8'hA1; exp_w[1] = 8'hB2; exp_w[2] = 8'hC3; exp_w[3] = 8'hD4;
    b_cpu_addr = 16'h4014; b_cpu_rw = 1'b0; b_cpu_data = 8'h07;
    next_cycle();
    b_cpu_addr = 16'h8000; b_cpu_rw = 1'b1; b_cpu_data = 8'h00;
    w = 0; stall_cnt = 0; n = 0; al = 1'b0; fin = 1'b0;
    while (!fin && n < 40) begin
      @(negedge clk);
      if (b_stall) begin
        if (stall_cnt == 0) al = ALIGN_ON && tb_par;
        if (b_bus_rw == 1'b0) begin
          if (w < 4) begin
            check_eq("b_write_addr", 32'(b_bus_addr), 32'h2004);
            check_eq("b_write_data", 32'(b_bus_data), 32'(exp_w[w]));
          end
          w++;
        end
        stall_cnt++;
      end else begin
        check_eq("b_done_pulse", 32'(b_done), 32'd1);
        fin = 1'b1;
      end
      n++;
      next_cycle();
    end
    if (!fin) check_eq("timeout_b", 32'd1, 32'd0);
    check_eq("b_stall_len", 32'(stall_cnt), 32'(9 + int'(al)));
    check_eq("b_write_count", 32'(w), 32'd4);
    @(negedge clk);
    check_eq("b_done_clear", 32'(b_done), 32'd0);
    next_cycle();
  endtask

  initial begin
    rst_n = 1'b0;
    a_cpu_addr = 16'h1234; a_cpu_rw = 1'b1; a_cpu_data = 8'h55;
    b_cpu_addr = 16'h8000; b_cpu_rw = 1'b1; b_cpu_data = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_stall", 32'(a_stall), 32'd0);
    check_eq("rst_busy", 32'(a_busy), 32'd0);
    check_eq("rst_done", 32'(a_done), 32'd0);
    check_eq("rst_pass_addr", 32'(a_bus_addr), 32'h1234);
    check_eq("rst_pass_rw", 32'(a_bus_rw), 32'd1);
    check_eq("rst_pass_data", 32'(a_bus_data), 32'h55);
    rst_n = 1'b1;
    next_cycle();

    // Read of the page register and write to its neighbour: no copy.
    a_cpu_addr = 16'h4014; a_cpu_rw = 1'b1; a_cpu_data = 8'h02;
    @(negedge clk);
    check_eq("rd4014_addr", 32'(a_bus_addr), 32'h4014);
    check_eq("rd4014_rw", 32'(a_bus_rw), 32'd1);
    next_cycle();
    a_cpu_addr = 16'h4015; a_cpu_rw = 1'b0; a_cpu_data = 8'h33;
    @(negedge clk);
    check_eq("rd4014_no_stall", 32'(a_stall), 32'd0);
    check_eq("rd4014_no_busy", 32'(a_busy), 32'd0);
    check_eq("wr4015_addr", 32'(a_bus_addr), 32'h4015);
    check_eq("wr4015_rw", 32'(a_bus_rw), 32'd0);
    check_eq("wr4015_data", 32'(a_bus_data), 32'h33);
    next_cycle();
    a_idle();
    @(negedge clk);
    check_eq("wr4015_no_stall", 32'(a_stall), 32'd0);
    check_eq("wr4015_no_busy", 32'(a_busy), 32'd0);
    next_cycle();

    run_b();
    run_a(8'h02, 1'b0, 1'b0);
    run_a(8'h02, 1'b1, 1'b0);
    next_cycle();
    run_a(8'h02, 1'b0, 1'b0);
    run_a(8'h02, 1'b0, 1'b1);
    run_a(8'h03, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
